// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL} state_t;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned OFFSET_W       = 5;
  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned INDEX_W        = 5;
  localparam int unsigned TAG_W          = 32 - INDEX_W - OFFSET_W;

  function automatic logic [INDEX_W-1:0] addr_index(logic [31:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(logic [31:0] addr);
    return addr[31 -: TAG_W];
  endfunction

  function automatic logic [2:0] addr_word(logic [31:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays: combinational read, synchronous word-write or full-line fill.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned TAG_BITS  = 22,
  parameter int unsigned IDX_BITS  = 5,
  parameter int unsigned WSEL_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_BITS-1:0]  idx,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 word_we,
  input  logic [WSEL_BITS-1:0] word_sel,
  input  logic [WORD_W-1:0]    word_data,
  input  logic                 fill_we,
  input  logic [TAG_BITS-1:0]  fill_tag,
  input  logic [LINE_BITS-1:0] fill_line
);

  logic [NUM_LINES-1:0] valid_arr;
  logic [NUM_LINES-1:0] dirty_arr;
  logic [TAG_BITS-1:0]  tag_arr  [NUM_LINES];
  logic [LINE_BITS-1:0] data_arr [NUM_LINES];

  assign rd_tag   = tag_arr[idx];
  assign rd_valid = valid_arr[idx];
  assign rd_dirty = dirty_arr[idx];
  assign rd_line  = data_arr[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_arr <= '0;
      dirty_arr <= '0;
    end else if (fill_we) begin
      valid_arr[idx] <= 1'b1;
      dirty_arr[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_arr[idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_arr[idx]  <= fill_tag;
      data_arr[idx] <= fill_line;
    end else if (word_we) begin
      data_arr[idx][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller between MEM stage and memory.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [WORD_W-1:0]    p1_data_i,
  output logic [WORD_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_WL = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WSEL_W = $clog2(LINE_BITS / WORD_W);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [LINE_BITS-1:0]  refill_q;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]  mem_data_q, mem_data_d;

  logic [ADDR_W-1:0]     cur_addr;
  logic [IDX_W-1:0]      idx;
  logic [TAG_WL-1:0]     tag;
  logic [WSEL_W-1:0]     wsel;
  logic [TAG_WL-1:0]     rd_tag;
  logic                  rd_valid, rd_dirty;
  logic [LINE_BITS-1:0]  rd_line;
  logic                  req, hit, miss;
  logic                  unused_byte_sel;

  // While a miss is in flight the latched address drives the array, not the frozen pipeline.
  assign cur_addr        = (state_q == IDLE) ? p1_addr_i : addr_q;
  assign idx             = cur_addr[OFF_W +: IDX_W];
  assign tag             = cur_addr[ADDR_W-1 -: TAG_WL];
  assign wsel            = cur_addr[2 +: WSEL_W];
  assign unused_byte_sel = ^cur_addr[1:0];

  assign req  = p1_MemRead_i | p1_MemWrite_i;
  assign hit  = (state_q == IDLE) & req & rd_valid & (rd_tag == tag);
  assign miss = (state_q == IDLE) & req & ~hit;

  assign p1_stall_o = (state_q != IDLE) | miss;
  assign p1_data_o  = hit ? rd_line[wsel*WORD_W +: WORD_W] : '0;

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS),
    .TAG_BITS  (TAG_WL),
    .IDX_BITS  (IDX_W),
    .WSEL_BITS (WSEL_W)
  ) u_sram (
    .clk       (clk_i),
    .rst       (rst_i),
    .idx       (idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .word_we   (hit & p1_MemWrite_i),
    .word_sel  (wsel),
    .word_data (p1_data_i),
    .fill_we   (state_q == FILL),
    .fill_tag  (tag),
    .fill_line (refill_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (miss) state_d = (rd_valid & rd_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) state_d = FILL;
      FILL:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Memory outputs are registered from the next state so they line up with the FSM.
  always_comb begin
    mem_en_d   = (state_d == WRITEBACK) | (state_d == ALLOCATE);
    mem_wr_d   = (state_d == WRITEBACK);
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (state_d == WRITEBACK && state_q == IDLE) begin
      mem_addr_d = {rd_tag, idx, {OFF_W{1'b0}}};
      mem_data_d = rd_line;
    end else if (state_d == ALLOCATE && state_q != ALLOCATE) begin
      mem_addr_d = {tag, idx, {OFF_W{1'b0}}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      refill_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      if (miss) addr_q <= p1_addr_i;
      if (state_q == ALLOCATE && mem_ack_i) refill_q <= mem_data_i;
    end
  end

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule
